// File: rtl/ssd_mux_driver.sv
// ----------------------------------------------------------------------------
// ssd_mux_driver
//
// Time-multiplexed driver for a NUM_DIGITS-digit, 7-segment hex display.
// A free-running prescaler sets the length of each digit slot. digit_sel steps
// through the digits, one per slot. A new value is staged in a pending register
// and is copied to the display register only at a frame boundary, so a single
// frame never mixes nibbles from two different values. Segment output can be
// dimmed by PWM, blanked, or have its leading zeros suppressed.
//
// Ports
//   clk         : clock; all state changes on the rising edge
//   rst_n       : asynchronous active-low reset; its release is synchronised
//                 internally
//   value       : new display value; nibble k drives digit k (digit 0 is the LSD)
//   load        : when high, value is captured into the pending register
//   lzs         : leading-zero suppression enable
//   blank       : turns all segments off
//   brightness  : duty level; 15 is full on, 0 is 1/16 of each slot
//   segments    : registered segment drive, active-high
//   digit_sel   : registered index of the lit digit
//   pending     : high while a loaded value waits for the next frame boundary
// ----------------------------------------------------------------------------
module ssd_mux_driver #(
  parameter int NUM_DIGITS = 2,   // 2..8
  parameter int DIV_WIDTH  = 15   // 4..24; one slot lasts 2**DIV_WIDTH clocks
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [4*NUM_DIGITS-1:0]       value,
  input  logic                          load,
  input  logic                          lzs,
  input  logic                          blank,
  input  logic [3:0]                    brightness,
  output logic [6:0]                    segments,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_sel,
  output logic                          pending
);

  localparam int SEL_W = $clog2(NUM_DIGITS);
  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_DIGITS - 1);

  // Reset release synchroniser. Reset assertion clears the chain at once, but
  // 'run' goes high only two edges after rst_n rises. The first timer count
  // therefore never lands on the edge where reset is released.
  logic [1:0] rst_sync;
  logic       run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign run = rst_sync[1];

  logic [DIV_WIDTH-1:0] timer, timer_nxt;
  logic [VAL_W-1:0]     disp, disp_nxt;
  logic [VAL_W-1:0]     pend_val, pend_val_nxt;
  logic [SEL_W-1:0]     sel_nxt;
  logic                 pend_nxt;
  logic                 tick, wrap;
  logic                 pwm_off, suppress;
  logic [3:0]           nibble;
  logic [6:0]           seg_nxt;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'b1111011;
      4'h1: seg = 7'b0110000;
      4'h2: seg = 7'b1011101;
      4'h3: seg = 7'b1111100;
      4'h4: seg = 7'b0110110;
      4'h5: seg = 7'b1101110;
      4'h6: seg = 7'b1101111;
      4'h7: seg = 7'b0111000;
      4'h8: seg = 7'b1111111;
      4'h9: seg = 7'b1111110;
      4'hA: seg = 7'b0111111;
      4'hB: seg = 7'b1100111;
      4'hC: seg = 7'b1001011;
      4'hD: seg = 7'b1110101;
      4'hE: seg = 7'b1001111;
      4'hF: seg = 7'b0001111;
    endcase
    return seg;
  endfunction

  // The segment pattern is computed from the values the timer, digit_sel and
  // display register will hold after this edge. The segments register then
  // always matches the digit_sel register that is updated on the same edge,
  // and a frame-boundary display update shows up on the first digit of the
  // new frame.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block
    // leaves a value unassigned and no latch is inferred.
    timer_nxt    = timer + DIV_WIDTH'(1);
    tick         = &timer;
    wrap         = tick && (digit_sel == LAST_SEL);
    sel_nxt      = digit_sel;
    disp_nxt     = disp;
    pend_val_nxt = pend_val;
    pend_nxt     = pending;

    // An explicit wrap at the last digit keeps a non-power-of-2 digit count
    // within range.
    if (tick) sel_nxt = wrap ? '0 : digit_sel + SEL_W'(1);

    // At a frame boundary, a staged value moves to the display. A load on the
    // same edge becomes the next staged value, so pending stays set.
    if (wrap && pending) disp_nxt = pend_val;
    if (load) begin
      pend_val_nxt = value;
      pend_nxt     = 1'b1;
    end else if (wrap) begin
      pend_nxt = 1'b0;
    end

    pwm_off  = timer_nxt[DIV_WIDTH-1 -: 4] > brightness;
    suppress = lzs && (sel_nxt != '0) && ((disp_nxt >> {sel_nxt, 2'b00}) == '0);
    nibble   = disp_nxt[{sel_nxt, 2'b00} +: 4];

    if (blank || pwm_off || suppress) seg_nxt = 7'b0000000;
    else                              seg_nxt = hex_to_seg(nibble);
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops read
  // their pre-edge values, whatever order the simulator evaluates them in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer     <= '0;
      digit_sel <= '0;
      disp      <= '0;
      pend_val  <= '0;
      pending   <= 1'b0;
      segments  <= 7'b0000000;
    end else if (!run) begin
      // Hold the reset state until the synchronised release arrives.
      timer     <= '0;
      digit_sel <= '0;
      disp      <= '0;
      pend_val  <= '0;
      pending   <= 1'b0;
      segments  <= 7'b0000000;
    end else begin
      timer     <= timer_nxt;
      digit_sel <= sel_nxt;
      disp      <= disp_nxt;
      pend_val  <= pend_val_nxt;
      pending   <= pend_nxt;
      segments  <= seg_nxt;
    end
  end

endmodule
